// File: rtl/counter_bg_updown_if.sv
// Control/observation bundle for counter_bg_updown: step/load controls in, encoded count and tc out.
// master drives the controls; slave is the counter itself.
interface counter_bg_updown_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             dir;
  logic             mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;

  modport master (
    output en, dir, mode, load, load_val,
    input  count, tc
  );

  modport slave (
    input  en, dir, mode, load, load_val,
    output count, tc
  );
endinterface

// File: rtl/counter_bg_updown.sv
// Up/down counter with binary or Gray output, parallel load, enable and optional saturation.
// count is registered (one cycle after the sampling edge); tc is combinational; accepts controls every cycle.
module counter_bg_updown #(
  parameter int WIDTH    = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  counter_bg_updown_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX_IDX = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] term_idx;
  logic             at_term;

  always_comb begin
    term_idx = bus.dir ? '0 : MAX_IDX;
    at_term  = (idx_q == term_idx);
    idx_d    = idx_q;
    if (bus.load) begin
      idx_d = bus.load_val;
    end else if (bus.en && !(SATURATE && at_term)) begin
      idx_d = bus.dir ? (idx_q - ONE) : (idx_q + ONE);
    end
    // Encode the next index so a mode change and a step land on the same edge.
    count_d = bus.mode ? (idx_d ^ (idx_d >> 1)) : idx_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = bus.en & ~bus.load & at_term;
endmodule

// File: tb/tb_counter_bg_updown.sv
// Scoreboarded bench for counter_bg_updown: four instances (WIDTH 3/5 x SATURATE 0/1) share one stimulus stream.
module tb_counter_bg_updown;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, dir = 1'b0, mode = 1'b0, load = 1'b0;
  logic [4:0] load_val = '0;

  always #5 clk = ~clk;

  counter_bg_updown_if #(.WIDTH(3)) b0 ();
  counter_bg_updown_if #(.WIDTH(3)) b1 ();
  counter_bg_updown_if #(.WIDTH(5)) b2 ();
  counter_bg_updown_if #(.WIDTH(5)) b3 ();

  counter_bg_updown #(.WIDTH(3), .SATURATE(1'b0)) u0 (.clk_i(clk), .rst_ni(rst_n), .bus(b0.slave));
  counter_bg_updown #(.WIDTH(3), .SATURATE(1'b1)) u1 (.clk_i(clk), .rst_ni(rst_n), .bus(b1.slave));
  counter_bg_updown #(.WIDTH(5), .SATURATE(1'b0)) u2 (.clk_i(clk), .rst_ni(rst_n), .bus(b2.slave));
  counter_bg_updown #(.WIDTH(5), .SATURATE(1'b1)) u3 (.clk_i(clk), .rst_ni(rst_n), .bus(b3.slave));

  assign b0.en = en;  assign b0.dir = dir;  assign b0.mode = mode;  assign b0.load = load;
  assign b1.en = en;  assign b1.dir = dir;  assign b1.mode = mode;  assign b1.load = load;
  assign b2.en = en;  assign b2.dir = dir;  assign b2.mode = mode;  assign b2.load = load;
  assign b3.en = en;  assign b3.dir = dir;  assign b3.mode = mode;  assign b3.load = load;
  assign b0.load_val = load_val[2:0];
  assign b1.load_val = load_val[2:0];
  assign b2.load_val = load_val;
  assign b3.load_val = load_val;

  logic [4:0] cnt [4];
  logic       tcv [4];
  assign cnt[0] = {2'b00, b0.count};  assign tcv[0] = b0.tc;
  assign cnt[1] = {2'b00, b1.count};  assign tcv[1] = b1.tc;
  assign cnt[2] = b2.count;           assign tcv[2] = b2.tc;
  assign cnt[3] = b3.count;           assign tcv[3] = b3.tc;

  // One entry per driven cycle: tc before the edge, count after it, optional extra properties.
  typedef struct packed {
    logic [3:0]  mask;
    logic [3:0]  tc_exp;
    logic [19:0] cnt_exp;
    logic        pre_chk;
    logic [3:0]  gray_chk;
    int          tag;
  } item_t;

  item_t sb_q [$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Hand-computed directed vectors (count after each edge; tc bit0 = WIDTH3 wrap, bit1 = WIDTH3 saturate)
  localparam logic [2:0] T1_A [8]  = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd0};
  localparam logic [2:0] T1_B [8]  = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd4};
  localparam logic [1:0] T1_TC [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11};
  localparam logic [2:0] T2_A [9]  = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
  localparam logic [1:0] T2_TC [9] = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11};
  localparam logic [2:0] T3_A [11] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd1};
  localparam logic [2:0] T3_B [11] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7, 3'd6};
  localparam logic [1:0] T3_TC [11] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                                        2'b11, 2'b10, 2'b10, 2'b00};

  // Monitor: tc and async-reset value just before the edge, count and Gray step just after it.
  item_t      mit;
  logic [4:0] pre_cnt [4];
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (sb_q.size() != 0) begin
        mit = sb_q.pop_front();
        for (int k = 0; k < 4; k++) begin
          pre_cnt[k] = cnt[k];
          if (mit.mask[k]) begin
            n_checks++;
            if (tcv[k] !== mit.tc_exp[k]) begin
              n_fail++;
              $display("FAIL tc tag%0d dut%0d: got %b want %b", mit.tag, k, tcv[k], mit.tc_exp[k]);
            end
            if (mit.pre_chk) begin
              n_checks++;
              if (cnt[k] !== 5'd0) begin
                n_fail++;
                $display("FAIL async_reset tag%0d dut%0d: count %0d want 0", mit.tag, k, cnt[k]);
              end
            end
          end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
          if (mit.mask[k]) begin
            n_checks++;
            if (cnt[k] !== mit.cnt_exp[k*5 +: 5]) begin
              n_fail++;
              $display("FAIL count tag%0d dut%0d: got %0d want %0d", mit.tag, k, cnt[k], mit.cnt_exp[k*5 +: 5]);
            end
            if (mit.gray_chk[k]) begin
              n_checks++;
              if ($countones(pre_cnt[k] ^ cnt[k]) != 1) begin
                n_fail++;
                $display("FAIL gray_step tag%0d dut%0d: %0d bits changed want 1", mit.tag, k,
                         $countones(pre_cnt[k] ^ cnt[k]));
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "timeout");
  end

  task automatic dstep(input int tag, input logic r, e, d, m, l, input logic [4:0] lv,
                       input logic [1:0] tcx, input logic [2:0] c0, c1,
                       input logic [1:0] gray, input logic pre);
    item_t it;
    @(negedge clk);
    rst_n = r; en = e; dir = d; mode = m; load = l; load_val = lv;
    it.mask     = 4'b0011;
    it.tc_exp   = {2'b00, tcx};
    it.cnt_exp  = {10'd0, 2'b00, c1, 2'b00, c0};
    it.pre_chk  = pre;
    it.gray_chk = {2'b00, gray};
    it.tag      = tag;
    sb_q.push_back(it);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_val = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [4:0] top_of(int k);
    return (k < 2) ? 5'h07 : 5'h1f;
  endfunction

  function automatic logic [4:0] ref_next(int k, logic [4:0] i, logic e, d, l, logic [4:0] lv);
    logic [4:0] top;
    logic       sat;
    top = top_of(k);
    sat = (k == 1) || (k == 3);
    if (l)             return lv & top;
    if (!e)            return i;
    if (!d)            return (sat && i == top) ? i : ((i + 5'd1) & top);
    return (sat && i == 5'd0) ? i : ((i - 5'd1) & top);
  endfunction

  logic [4:0] m_idx [4];
  logic       prev_mode;

  initial begin
    item_t      it;
    logic [4:0] nx;
    // Reset state
    dstep(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 3'd0, 3'd0, 2'b00, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    // Gray up through the wrap
    for (int s = 0; s < 8; s++)
      dstep(100 + s, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, T1_TC[s], T1_A[s], T1_B[s], 2'b01, 1'b0);
    // Binary down from reset: wrap vs hold at zero
    do_reset();
    for (int s = 0; s < 9; s++)
      dstep(200 + s, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, T2_TC[s], T2_A[s], 3'd0, 2'b00, 1'b0);
    // Binary up past the top, then reverse
    do_reset();
    for (int s = 0; s < 11; s++)
      dstep(300 + s, 1'b1, 1'b1, (s == 10), 1'b0, 1'b0, 5'd0, T3_TC[s], T3_A[s], T3_B[s], 2'b00, 1'b0);
    // Load beats enable, then re-encode held index, then step in Gray
    do_reset();
    dstep(400, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 2'b00, 3'd5, 3'd5, 2'b00, 1'b0);
    dstep(401, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 2'b00, 3'd7, 3'd7, 2'b00, 1'b0);
    dstep(402, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 2'b00, 3'd5, 3'd5, 2'b00, 1'b0);
    // Async reset mid-count
    do_reset();
    for (int s = 0; s < 6; s++)
      dstep(500 + s, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 3'(s + 1), 3'(s + 1), 2'b00, 1'b0);
    for (int s = 0; s < 4; s++)
      dstep(510 + s, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 3'd0, 3'd0, 2'b00, 1'b1);
    dstep(520, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 3'd1, 3'd1, 2'b00, 1'b0);

    // Random phase against the reference model, all four instances
    do_reset();
    for (int k = 0; k < 4; k++) m_idx[k] = 5'd0;
    prev_mode = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      en       = ($urandom_range(0, 3) != 0);
      dir      = 1'($urandom_range(0, 1));
      load     = ($urandom_range(0, 15) == 0);
      load_val = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      it.mask     = 4'b1111;
      it.pre_chk  = 1'b0;
      it.tag      = 1000 + c;
      for (int k = 0; k < 4; k++) begin
        it.tc_exp[k] = en & ~load & (m_idx[k] == (dir ? 5'd0 : top_of(k)));
        nx = ref_next(k, m_idx[k], en, dir, load, load_val);
        it.cnt_exp[k*5 +: 5] = mode ? (nx ^ (nx >> 1)) : nx;
        it.gray_chk[k] = mode & prev_mode & ~load & en & (nx != m_idx[k]);
        m_idx[k] = nx;
      end
      prev_mode = mode;
      sb_q.push_back(it);
    end

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
